// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle MIPS datapath with a shared ALU and unified memory.
// Steps each instruction through fetch/decode/execute/memory/writeback and stalls on mem_ready.
module multicycle_ctrl #(
  parameter bit WAIT_MEM = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op_code,
  input  logic [5:0] Funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       IorD,
  output logic       Mem_write,
  output logic       IR_write,
  output logic       Reg_dst,
  output logic       Memtoreg,
  output logic       Reg_write,
  output logic       ALU_srcA,
  output logic [1:0] ALU_srcB,
  output logic [2:0] ALU_control,
  output logic [1:0] PC_src,
  output logic       PC_en,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEX   = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state_q;
  state_t state_n;
  logic   illegal_q;
  logic   ready;
  logic   decode_illegal;

  function automatic logic funct_legal(input logic [5:0] fn);
    case (fn)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_legal = 1'b1;
      default:                               funct_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] alu_for_funct(input logic [5:0] fn);
    case (fn)
      FN_SUB:  alu_for_funct = ALU_SUB;
      FN_AND:  alu_for_funct = ALU_AND;
      FN_OR:   alu_for_funct = ALU_OR;
      FN_SLT:  alu_for_funct = ALU_SLT;
      default: alu_for_funct = ALU_ADD;
    endcase
  endfunction

  function automatic logic opcode_legal(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: opcode_legal = 1'b1;
      OP_RTYPE:                            opcode_legal = funct_legal(fn);
      default:                             opcode_legal = 1'b0;
    endcase
  endfunction

  // With WAIT_MEM cleared the memory is assumed to answer in a single cycle.
  assign ready          = WAIT_MEM ? mem_ready : 1'b1;
  assign decode_illegal = !opcode_legal(Op_code, Funct);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_n;
      if (state_q == DECODE && decode_illegal)
        illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_n     = FETCH;
    IorD        = 1'b0;
    Mem_write   = 1'b0;
    IR_write    = 1'b0;
    Reg_dst     = 1'b0;
    Memtoreg    = 1'b0;
    Reg_write   = 1'b0;
    ALU_srcA    = 1'b0;
    ALU_srcB    = 2'b00;
    ALU_control = ALU_ADD;
    PC_src      = 2'b00;
    PC_en       = 1'b0;
    instr_done  = 1'b0;

    case (state_q)
      FETCH: begin
        ALU_srcB = 2'b01;
        IR_write = ready;
        PC_en    = ready;
        state_n  = ready ? DECODE : FETCH;
      end
      DECODE: begin
        // Branch target is computed speculatively here and parked in ALUOut.
        ALU_srcB = 2'b11;
        if (decode_illegal) begin
          instr_done = 1'b1;
          state_n    = FETCH;
        end else begin
          case (Op_code)
            OP_LW, OP_SW: state_n = MEMADR;
            OP_RTYPE:     state_n = EXECUTE;
            OP_BEQ:       state_n = BRANCH;
            OP_ADDI:      state_n = ADDIEX;
            OP_J:         state_n = JUMP;
            default:      state_n = FETCH;
          endcase
        end
      end
      MEMADR: begin
        ALU_srcA = 1'b1;
        ALU_srcB = 2'b10;
        state_n  = (Op_code == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        IorD    = 1'b1;
        state_n = ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        Memtoreg   = 1'b1;
        Reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      MEMWRITE: begin
        IorD       = 1'b1;
        Mem_write  = 1'b1;
        instr_done = ready;
        state_n    = ready ? FETCH : MEMWRITE;
      end
      EXECUTE: begin
        ALU_srcA    = 1'b1;
        ALU_control = alu_for_funct(Funct);
        state_n     = ALUWB;
      end
      ALUWB: begin
        Reg_dst    = 1'b1;
        Reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        ALU_srcA    = 1'b1;
        ALU_control = ALU_SUB;
        PC_src      = 2'b01;
        PC_en       = zero;
        instr_done  = 1'b1;
      end
      ADDIEX: begin
        ALU_srcA = 1'b1;
        ALU_srcB = 2'b10;
        state_n  = ADDIWB;
      end
      ADDIWB: begin
        Reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      JUMP: begin
        PC_src     = 2'b10;
        PC_en      = 1'b1;
        instr_done = 1'b1;
      end
      default: state_n = FETCH;
    endcase

    // An abandoned instruction must never commit anything while reset is held.
    if (!reset) begin
      Mem_write  = 1'b0;
      IR_write   = 1'b0;
      Reg_write  = 1'b0;
      PC_en      = 1'b0;
      instr_done = 1'b0;
    end
  end

  assign illegal_op = illegal_q;
  assign state      = state_q;

endmodule
